horner_ctrl: RTL and testbench
==============================

HORNER_CTRL -- requirements
Module: horner_ctrl

Interface
REQ-001 The block SHALL have `clk` as input, width 1: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have `rst` as input, width 1: asynchronous, active-low reset.
REQ-003 The block SHALL have `inicio` as input, width 1: start request, sampled on the rising edge of `clk`.
REQ-004 The block SHALL have `x` as input, width 8: polynomial variable, treated as unsigned.
REQ-005 The block SHALL have `A`, `B`, `C` as inputs, width 16 each: polynomial coefficients, treated as unsigned.
REQ-006 The block SHALL have `resultado` as output, width 16: registered result of A*x^2 + B*x + C, modulo 2^16.
REQ-007 The block SHALL have `pronto` as output, width 1: one-cycle pulse indicating `resultado` is valid.
REQ-008 The block SHALL have `ocupado` as output, width 1: high in every state except IDLE.
REQ-009 The block SHALL have `ovf` as output, width 1: sticky overflow flag for the current operation.

Function
REQ-010 Evaluation SHALL use Horner's form H = (A*x + B)*x + C, through one shared 16x16 multiplier and one 16-bit adder.
REQ-011 The FSM SHALL have exactly these states: IDLE, MAC1, MAC2, DONE.
REQ-012 In IDLE with `inicio`=1 at an edge, the block SHALL latch `x` (zero-extended to 16 bits), `B` and `C`, load H<=A, clear `ovf`, and go to MAC1.
REQ-013 In MAC1, the block SHALL set H<=low16(H*Xq)+Bq, with the sum taken modulo 2^16, and go to MAC2.
REQ-014 In MAC2, the block SHALL set H<=low16(H*Xq)+Cq, load `resultado` with the same value, and go to DONE.
REQ-015 In DONE, `pronto`=1 for exactly one cycle, then the block SHALL go to IDLE.
REQ-016 The latency from the accepting edge to `pronto` high SHALL be 3 clock edges; the initiation interval SHALL be 4 cycles.
REQ-017 `inicio` SHALL be ignored in MAC1, MAC2 and DONE; a request held high through DONE SHALL be accepted at the first IDLE edge.
REQ-018 Operand inputs SHALL NOT affect a running operation after the accepting edge.
REQ-019 `resultado` SHALL hold its value until the next MAC2 completes.
REQ-020 When x=0, the result SHALL equal C; when A=B=0, the result SHALL equal C.

Reset
REQ-021 When `rst`=0, the block SHALL immediately, without waiting for a clock edge, set the state to IDLE and set H, the latched operands, `resultado`, `pronto`, `ocupado` and `ovf` to 0.
REQ-022 A reset asserted mid-operation (MAC1, MAC2 or DONE) SHALL abort the operation, with no `pronto` pulse.
REQ-023 After `rst` deasserts, the first accepted `inicio` SHALL behave exactly as after power-up.

Configuration
REQ-024 With macro HORNER_OVF_EN defined, in MAC1 and MAC2 `ovf` SHALL be set if the upper 16 product bits are nonzero or the 16-bit add carries out.
REQ-025 With HORNER_OVF_EN defined, `ovf` SHALL stay set until the next accepted `inicio` or reset.
REQ-026 With HORNER_OVF_EN undefined, `ovf` SHALL be tied to 0 and no overflow logic SHALL be synthesized.
REQ-027 Functional results SHALL be identical with and without HORNER_OVF_EN.

Verification
REQ-028 Basic case: x=2, A=5, B=3, C=4, `inicio` pulsed -> `resultado`=30, `pronto` pulse exactly 3 edges after acceptance, `ovf`=0.
REQ-029 Zero variable: x=0, A=9, B=9, C=0x1234 -> `resultado`=0x1234.
REQ-030 Overflow: x=255, A=0x0100, B=0x0100, C=7 -> `resultado`=7; `ovf`=1 with HORNER_OVF_EN, 0 without.
REQ-031 Busy handling: `inicio` held high for 10 cycles with x=2, A=5, B=3, C=4 -> two completed operations, `pronto` pulses 4 cycles apart, `ocupado` low for exactly one cycle between them.
REQ-032 Reset abort: `rst`=0 asserted during MAC2 -> all outputs 0 asynchronously, no `pronto` pulse; a new run with x=1, A=B=C=1 -> `resultado`=3.
REQ-033 Operand stability: operands changed to x=3, A=1, B=1, C=1 one cycle after acceptance of the basic case -> `resultado` still 30.

Source files
------------

// File: rtl/horner_ctrl.sv
// Quadratic evaluator A*x^2 + B*x + C in Horner form, reusing one multiplier and one adder.
// Optional overflow flag enabled by defining HORNER_OVF_EN; without it ovf is tied low.
module horner_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        inicio,
  input  logic [7:0]  x,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] C,
  output logic [15:0] resultado,
  output logic        pronto,
  output logic        ocupado,
  output logic        ovf
);

  // state | meaning
  // IDLE  | waiting for inicio; operands latched and H<=A on acceptance
  // MAC1  | H <= H*x + B
  // MAC2  | H <= H*x + C, result register loaded
  // DONE  | pronto pulse, back to IDLE next edge
  typedef enum logic [1:0] {IDLE, MAC1, MAC2, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] h_q, h_d;
  logic [15:0] xq_q, xq_d;
  logic [15:0] bq_q, bq_d;
  logic [15:0] cq_q, cq_d;
  logic [15:0] res_q, res_d;
  logic        pronto_q, pronto_d;
  logic        ocupado_q, ocupado_d;

  logic [15:0] addend;
  logic [15:0] mac;

  assign addend = (state_q == MAC1) ? bq_q : cq_q;

`ifdef HORNER_OVF_EN
  logic [31:0] prod;
  logic [16:0] sum;
  logic        mac_ovf;
  logic        ovf_q, ovf_d;

  always_comb begin
    prod    = {16'b0, h_q} * {16'b0, xq_q};
    sum     = {1'b0, prod[15:0]} + {1'b0, addend};
    mac     = sum[15:0];
    mac_ovf = (prod[31:16] != 16'b0) | sum[16];
  end

  assign ovf = ovf_q;
`else
  logic [15:0] prod;

  always_comb begin
    prod = h_q * xq_q;
    mac  = prod + addend;
  end

  assign ovf = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    xq_d     = xq_q;
    bq_d     = bq_q;
    cq_d     = cq_q;
    res_d    = res_q;
    pronto_d = 1'b0;
`ifdef HORNER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (inicio) begin
          xq_d    = {8'b0, x};
          bq_d    = B;
          cq_d    = C;
          h_d     = A;
`ifdef HORNER_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = MAC1;
        end
      end
      MAC1: begin
        h_d     = mac;
`ifdef HORNER_OVF_EN
        ovf_d   = ovf_q | mac_ovf;
`endif
        state_d = MAC2;
      end
      MAC2: begin
        h_d      = mac;
        res_d    = mac;
        pronto_d = 1'b1;
`ifdef HORNER_OVF_EN
        ovf_d    = ovf_q | mac_ovf;
`endif
        state_d  = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // busy flag registered from the next state so it tracks the state register exactly
    ocupado_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      h_q       <= 16'b0;
      xq_q      <= 16'b0;
      bq_q      <= 16'b0;
      cq_q      <= 16'b0;
      res_q     <= 16'b0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
`ifdef HORNER_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      xq_q      <= xq_d;
      bq_q      <= bq_d;
      cq_q      <= cq_d;
      res_q     <= res_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
`ifdef HORNER_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign resultado = res_q;
  assign pronto    = pronto_q;
  assign ocupado   = ocupado_q;

endmodule

// File: tb/tb_horner_ctrl.sv
// Bench for horner_ctrl: vector table plus scoreboard, with busy, abort and stability sequences.
module tb_horner_ctrl;

  logic        clk;
  logic        rst;
  logic        inicio;
  logic [7:0]  x;
  logic [15:0] A, B, C;
  logic [15:0] resultado;
  logic        pronto, ocupado, ovf;

`ifdef HORNER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0]  vx;
    logic [15:0] va, vb, vc;
    logic [15:0] res;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    bit          chk_ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  horner_ctrl dut (
    .clk(clk), .rst(rst), .inicio(inicio), .x(x), .A(A), .B(B), .C(C),
    .resultado(resultado), .pronto(pronto), .ocupado(ocupado), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (pronto) begin
      if (sb.size() == 0) check("unexpected_pronto", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        check("resultado", {16'b0, resultado}, {16'b0, mon_e.res});
        if (mon_e.chk_ovf) check("ovf", {31'b0, ovf}, {31'b0, mon_e.ovf});
      end
    end
  end

  task automatic run_op(input logic [7:0] vx, input logic [15:0] va, input logic [15:0] vb,
                        input logic [15:0] vc, input logic [15:0] er, input logic eo, input bit co);
    int lat;
    @(negedge clk);
    x = vx; A = va; B = vb; C = vc; inicio = 1'b1;
    sb.push_back(exp_t'{er, eo, co});
    @(negedge clk);
    inicio = 1'b0;
    lat = 1;
    check("ocupado_run", {31'b0, ocupado}, 32'd1);
    while (!pronto && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 32'd3);
    @(negedge clk);
    check("pronto_one_cycle", {31'b0, pronto}, 32'd0);
    check("ocupado_idle", {31'b0, ocupado}, 32'd0);
  endtask

  function automatic logic [15:0] poly(input logic [7:0] vx, input logic [15:0] va,
                                       input logic [15:0] vb, input logic [15:0] vc);
    longint unsigned t;
    t = longint'(va) * longint'(vx) * longint'(vx) + longint'(vb) * longint'(vx) + longint'(vc);
    return t[15:0];
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int first, second, npr, nidle;
    logic [7:0]  rx;
    logic [15:0] ra, rb, rc;

    vecs[0] = '{8'd2,   16'd5,      16'd3,      16'd4,      16'd30,     1'b0};
    vecs[1] = '{8'd0,   16'd9,      16'd9,      16'h1234,   16'h1234,   1'b0};
    vecs[2] = '{8'd255, 16'h0100,   16'h0100,   16'd7,      16'd7,      1'b1};
    vecs[3] = '{8'd77,  16'd0,      16'd0,      16'hBEEF,   16'hBEEF,   1'b0};
    vecs[4] = '{8'd1,   16'd1,      16'd1,      16'd1,      16'd3,      1'b0};
    vecs[5] = '{8'd255, 16'hFFFF,   16'hFFFF,   16'hFFFF,   16'h00FF,   1'b1};
    vecs[6] = '{8'd10,  16'd100,    16'd200,    16'd300,    16'h300C,   1'b0};

    rst = 1'b0; inicio = 1'b0; x = '0; A = '0; B = '0; C = '0;
    repeat (2) @(negedge clk);
    check("rst_resultado", {16'b0, resultado}, 32'd0);
    check("rst_pronto", {31'b0, pronto}, 32'd0);
    check("rst_ocupado", {31'b0, ocupado}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].vx, vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].res, vecs[i].ovf & OVF_EN, 1'b1);

    for (int i = 0; i < 4; i++) begin
      rx = 8'($urandom_range(0, 255));
      ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom);
      run_op(rx, ra, rb, rc, poly(rx, ra, rb, rc), 1'b0, 1'b0);
    end

    // operands disturbed one cycle after acceptance
    @(negedge clk);
    x = 8'd2; A = 16'd5; B = 16'd3; C = 16'd4; inicio = 1'b1;
    sb.push_back(exp_t'{16'd30, 1'b0, 1'b1});
    @(negedge clk);
    inicio = 1'b0; x = 8'd3; A = 16'd1; B = 16'd1; C = 16'd1;
    repeat (4) @(negedge clk);
    check("stable_ocupado", {31'b0, ocupado}, 32'd0);

    // inicio held for 10 edges
    @(negedge clk);
    x = 8'd2; A = 16'd5; B = 16'd3; C = 16'd4; inicio = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(exp_t'{16'd30, 1'b0, 1'b1});
    first = -1; second = -1; npr = 0; nidle = 0;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      if (cyc == 10) inicio = 1'b0;
      if (pronto) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
        if (cyc <= 10) npr++;
      end
      if (cyc > 3 && cyc < 7 && !ocupado) nidle++;
    end
    check("busy_first_pronto", first, 32'd3);
    check("busy_pronto_spacing", second - first, 32'd4);
    check("busy_pronto_count", npr, 32'd2);
    check("busy_idle_cycles", nidle, 32'd1);
    @(negedge clk);
    check("busy_end_idle", {31'b0, ocupado}, 32'd0);

    // reset asserted while in MAC2
    @(negedge clk);
    x = 8'd2; A = 16'd5; B = 16'd3; C = 16'd4; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    check("abort_busy_before", {31'b0, ocupado}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_resultado", {16'b0, resultado}, 32'd0);
    check("abort_pronto", {31'b0, pronto}, 32'd0);
    check("abort_ocupado", {31'b0, ocupado}, 32'd0);
    check("abort_ovf", {31'b0, ovf}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run_op(8'd1, 16'd1, 16'd1, 16'd1, 16'd3, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("resultado_hold", {16'b0, resultado}, 32'd3);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
